// File: rtl/rv_pkg.sv
// Shared integer-core definitions for the register-file writer: widths,
// write-back entry layout, arbiter source encoding and a decoder helper.
package rv_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LSU  = 2'd2
  } wb_src_e;

  // One-hot register mask; x0 never produces a bit.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] r,
                                                  input logic en);
    logic [NREGS-1:0] m;
    m = '0;
    if (en && (r != '0)) m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small result FIFO for long-latency write-backs; wrap-around pointers with an
// extra bit to tell full from empty.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  wb_entry_t din_i,
  input  logic      pop_i,
  output wb_entry_t dout_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t   mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port owner: merges ALU and buffered LSU/MDU results into
// one registered write per cycle and tracks outstanding long-latency targets.
module regfile_wb_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_stall,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] chk_rs1,
  input  logic [REG_AW-1:0] chk_rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              w_ce,
  output logic [REG_AW-1:0] w_a,
  output logic [XLEN-1:0]   write_data
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  wb_entry_t         lsu_entry, head, sel;
  logic              fifo_full, fifo_empty, push, pop;
  wb_src_e           src;

  logic              w_ce_q, w_ce_d;
  logic [REG_AW-1:0] w_a_q, w_a_d;
  logic [XLEN-1:0]   w_data_q, w_data_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              stall_q, stall_d;

  // Ready comes from the registered pointers only, so it never depends on pop.
  assign lsu_ready = !fifo_full;
  assign push      = lsu_valid && !fifo_full;
  assign lsu_entry = '{rd: lsu_rd, data: lsu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (lsu_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    src = WB_NONE;
    if (alu_valid)        src = WB_ALU;
    else if (!fifo_empty) src = WB_LSU;
  end

  assign pop = (src == WB_LSU);

  always_comb begin
    sel      = '{rd: alu_rd, data: alu_data};
    w_ce_d   = 1'b0;
    w_a_d    = w_a_q;
    w_data_d = w_data_q;
    if (src == WB_LSU) sel = head;
    if (src != WB_NONE) begin
      w_ce_d   = (sel.rd != '0);
      w_a_d    = sel.rd;
      w_data_d = sel.data;
    end
  end

  // Clear lands on the same edge that raises w_ce for the LSU entry; a
  // same-cycle issue to that rd re-sets it because a newer op is outstanding.
  always_comb begin
    busy_d    = (busy_q & ~reg_onehot(head.rd, pop)) | reg_onehot(issue_rd, issue_valid);
    busy_d[0] = 1'b0;
  end

  always_comb begin
    starve_d = starve_q;
    stall_d  = stall_q;
    if (pop) begin
      starve_d = '0;
      stall_d  = 1'b0;
    end else begin
      if (fifo_full && (src == WB_ALU) && (starve_q != SMAX))
        starve_d = starve_q + CW'(1);
      if (starve_d == SMAX) stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ce_q   <= 1'b0;
      w_a_q    <= '0;
      w_data_q <= '0;
      busy_q   <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      w_ce_q   <= w_ce_d;
      w_a_q    <= w_a_d;
      w_data_q <= w_data_d;
      busy_q   <= busy_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign w_ce       = w_ce_q;
  assign w_a        = w_a_q;
  assign write_data = w_data_q;
  assign alu_stall  = stall_q;
  assign rs1_busy   = busy_q[chk_rs1];
  assign rs2_busy   = busy_q[chk_rs2];

`ifndef SYNTHESIS
  alu_stall_protocol : assert property (@(posedge clk) disable iff (rst)
    !(stall_q && alu_valid));
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: vector table plus hand sequences,
// expected writes queued at drive time and compared one edge later.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, issue_valid;
  logic [4:0]  alu_rd, lsu_rd, issue_rd, chk_rs1, chk_rs2;
  logic [31:0] alu_data, lsu_data;
  logic        alu_stall, lsu_ready, rs1_busy, rs2_busy, w_ce;
  logic [4:0]  w_a;
  logic [31:0] write_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .w_ce(w_ce), .w_a(w_a), .write_data(write_data)
  );

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] adat;
    logic        lv;  logic [4:0] lrd; logic [31:0] ldat;
    logic        iv;  logic [4:0] ird;
    logic [4:0]  c1;  logic [4:0] c2;
    logic        e_ready, e_b1, e_b2;
    logic        e_ce; logic [4:0] e_a; logic [31:0] e_d; logic e_stall;
  } vec_t;

  typedef struct {
    logic        ce; logic [4:0] a; logic [31:0] d; logic stall;
  } exp_t;

  exp_t expq[$];
  vec_t tbl[$];

  function automatic vec_t mk(input int av, input int ard, input logic [31:0] adat,
                              input int lv, input int lrd, input logic [31:0] ldat,
                              input int iv, input int ird, input int c1, input int c2,
                              input int er, input int eb1, input int eb2,
                              input int ece, input int ea, input logic [31:0] ed,
                              input int es);
    vec_t v;
    v.av = 1'(av);  v.ard = 5'(ard); v.adat = adat;
    v.lv = 1'(lv);  v.lrd = 5'(lrd); v.ldat = ldat;
    v.iv = 1'(iv);  v.ird = 5'(ird);
    v.c1 = 5'(c1);  v.c2 = 5'(c2);
    v.e_ready = 1'(er); v.e_b1 = 1'(eb1); v.e_b2 = 1'(eb2);
    v.e_ce = 1'(ece); v.e_a = 5'(ea); v.e_d = ed; v.e_stall = 1'(es);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0;
    chk_rs1 = 0; chk_rs2 = 0;
  endtask

  // Called at posedge+1: drive, check combinational outputs, queue the
  // expected registered write, then compare it after the next edge.
  task automatic step(input string tag, input vec_t v);
    exp_t e;
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
    lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ldat;
    issue_valid = v.iv; issue_rd = v.ird;
    chk_rs1 = v.c1; chk_rs2 = v.c2;
    #1;
    chk({tag, ".lsu_ready"}, 32'(lsu_ready), 32'(v.e_ready));
    chk({tag, ".rs1_busy"},  32'(rs1_busy),  32'(v.e_b1));
    chk({tag, ".rs2_busy"},  32'(rs2_busy),  32'(v.e_b2));
    expq.push_back('{ce: v.e_ce, a: v.e_a, d: v.e_d, stall: v.e_stall});
    @(posedge clk); #1;
    e = expq.pop_front();
    chk({tag, ".w_ce"},       32'(w_ce),      32'(e.ce));
    chk({tag, ".w_a"},        32'(w_a),       32'(e.a));
    chk({tag, ".write_data"}, write_data,     e.d);
    chk({tag, ".alu_stall"},  32'(alu_stall), 32'(e.stall));
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.w_ce", 32'(w_ce), 0);
    chk("rst.w_a", 32'(w_a), 0);
    chk("rst.write_data", write_data, 0);
    chk("rst.alu_stall", 32'(alu_stall), 0);
    chk("rst.lsu_ready", 32'(lsu_ready), 1);
    rst = 1'b0;

    // ALU only, conflict, scoreboard set/clear, set-wins, x0 drop
    tbl.push_back(mk(1,5,32'h1234,      0,0,0,          0,0,  0,0,  1,0,0, 1,5,32'h1234,0));
    tbl.push_back(mk(1,3,32'hAAAA0003,  1,7,32'h77,     0,0,  0,0,  1,0,0, 1,3,32'hAAAA0003,0));
    tbl.push_back(mk(0,0,0,             0,0,0,          0,0,  0,0,  1,0,0, 1,7,32'h77,0));
    tbl.push_back(mk(0,0,0,             0,0,0,          1,9,  9,0,  1,0,0, 0,7,32'h77,0));
    tbl.push_back(mk(0,0,0,             1,9,32'h99,     0,0,  9,0,  1,1,0, 0,7,32'h77,0));
    tbl.push_back(mk(0,0,0,             0,0,0,          0,0,  9,9,  1,1,1, 1,9,32'h99,0));
    tbl.push_back(mk(0,0,0,             0,0,0,          1,0,  9,0,  1,0,0, 0,9,32'h99,0));
    tbl.push_back(mk(0,0,0,             0,0,0,          1,12, 0,12, 1,0,0, 0,9,32'h99,0));
    tbl.push_back(mk(1,12,32'h5,        0,0,0,          0,0,  0,12, 1,0,1, 1,12,32'h5,0));
    tbl.push_back(mk(0,0,0,             1,12,32'hC,     0,0,  0,12, 1,0,1, 0,12,32'h5,0));
    tbl.push_back(mk(0,0,0,             0,0,0,          1,12, 0,12, 1,0,1, 1,12,32'hC,0));
    tbl.push_back(mk(0,0,0,             1,12,32'hD,     0,0,  0,12, 1,0,1, 0,12,32'hC,0));
    tbl.push_back(mk(0,0,0,             0,0,0,          0,0,  0,12, 1,0,1, 1,12,32'hD,0));
    tbl.push_back(mk(0,0,0,             0,0,0,          0,0,  0,12, 1,0,0, 0,12,32'hD,0));
    tbl.push_back(mk(0,0,0,             1,0,32'hFFFF,   0,0,  0,0,  1,0,0, 0,12,32'hD,0));
    tbl.push_back(mk(0,0,0,             0,0,0,          0,0,  0,0,  1,0,0, 0,0,32'hFFFF,0));
    tbl.push_back(mk(0,0,0,             0,0,0,          0,0,  0,0,  1,0,0, 0,0,32'hFFFF,0));
    for (int i = 0; i < tbl.size(); i++) step($sformatf("tbl%0d", i), tbl[i]);

    // Starvation: fill FIFO under ALU traffic, stall after four full cycles
    step("fill0", mk(1,1,32'h101, 1,2,32'h202, 0,0, 0,0, 1,0,0, 1,1,32'h101, 0));
    step("fill1", mk(1,1,32'h102, 1,3,32'h303, 0,0, 0,0, 1,0,0, 1,1,32'h102, 0));
    for (int k = 0; k < 4; k++)
      step($sformatf("starve%0d", k),
           mk(1,1,32'h110 + 32'(k), 0,0,0, 0,0, 0,0, 0,0,0, 1,1,32'h110 + 32'(k), (k == 3) ? 1 : 0));
    step("drop0", mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0, 1,2,32'h202, 0));
    step("drop1", mk(0,0,0, 0,0,0, 0,0, 0,0, 1,0,0, 1,3,32'h303, 0));

    // Reset mid-operation with a full FIFO and a busy register
    step("pre0", mk(1,1,32'h1, 1,4,32'h44, 1,4, 0,0, 1,0,0, 1,1,32'h1, 0));
    step("pre1", mk(1,1,32'h2, 1,5,32'h55, 0,0, 4,0, 1,1,0, 1,1,32'h2, 0));
    alu_valid = 1; alu_rd = 6; alu_data = 32'h66; chk_rs1 = 4;
    #1;
    chk("pre.lsu_ready", 32'(lsu_ready), 0);
    chk("pre.rs1_busy", 32'(rs1_busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst.w_ce", 32'(w_ce), 0);
    chk("mid_rst.w_a", 32'(w_a), 0);
    chk("mid_rst.write_data", write_data, 0);
    chk("mid_rst.lsu_ready", 32'(lsu_ready), 1);
    chk("mid_rst.rs1_busy", 32'(rs1_busy), 0);
    drive_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    step("post0", mk(0,0,0, 0,0,0, 0,0, 4,5, 1,0,0, 0,0,0, 0));
    step("post1", mk(0,0,0, 0,0,0, 0,0, 4,0, 1,0,0, 0,0,0, 0));

    if (expq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL queue_drain: %0d entries left, expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit 100000");
    $fatal(1);
  end

endmodule
